// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared pipeline types and defaults for the memory arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_IF = 2'd1,
      RD_D  = 2'd2
   } rd_state_t;
   localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and data requesters.
// Data has priority; fetch is forced through after STARVE_MAX lost cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   rd_state_t  state, state_nxt;
   logic [3:0] starve_cnt, starve_nxt;
   logic       force_if;
   // Grants are masked during reset so nothing escapes while rst_n is low.
   always_comb begin
      force_if   = (starve_cnt == SMAX);
      d_gnt      = rst_n && d_req && !(if_req && force_if);
      if_gnt     = rst_n && if_req && !d_gnt;
      mem_en     = if_gnt || d_gnt;
      mem_addr   = d_gnt ? {d_addr[31:2], 2'b00} : if_gnt ? {if_addr[31:2], 2'b00} : 32'h0;
      mem_we     = (d_gnt && d_we) ? d_wstrb : 4'b0000;
      mem_wdata  = d_wdata;
      state_nxt  = if_gnt ? RD_IF : (d_gnt && !d_we) ? RD_D : IDLE;
      starve_nxt = (if_req && !if_gnt) ? (force_if ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end
   always_comb begin
      if_rvalid = (state == RD_IF);
      d_rvalid  = (state == RD_D);
      if_rdata  = if_rvalid ? mem_rdata : 32'h0;
      d_rdata   = d_rvalid ? mem_rdata : 32'h0;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles a pending fetch may lose arbitration before it is forced to win (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  fetch request from IF stage.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1  fetch data valid.
REQ-008 SHALL have port if_rdata  output  32  fetch data.
REQ-009 SHALL have port d_req  input  1  data access request from MEM stage.
REQ-010 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have port d_addr  input  32  data byte address.
REQ-012 SHALL have port d_wdata  input  32  write data.
REQ-013 SHALL have port d_wstrb  input  4  byte-lane write enables.
REQ-014 SHALL have port d_gnt  output  1  data access accepted this cycle.
REQ-015 SHALL have port d_rvalid  output  1  read data valid.
REQ-016 SHALL have port d_rdata  output  32  read data.
REQ-017 SHALL have port mem_en  output  1  memory access strobe.
REQ-018 SHALL have port mem_we  output  4  memory byte write enables.
REQ-019 SHALL have port mem_addr  output  32  memory address, word-aligned.
REQ-020 SHALL have port mem_wdata  output  32  memory write data.
REQ-021 SHALL have port mem_rdata  input  32  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-022 SHALL grant at most one requester per cycle; grants are combinational from the requests and the current state.
REQ-023 SHALL grant data over fetch when both request, unless starve_cnt == STARVE_MAX, in which case it SHALL grant fetch.
REQ-024 SHALL increment starve_cnt (4-bit, saturating at STARVE_MAX) each cycle that if_req=1 and if_gnt=0, and SHALL clear it on any cycle with if_gnt=1 or if_req=0.
REQ-025 SHALL drive the memory strobes as follows on any grant:
- mem_en=1.
- mem_addr = {granted addr[31:2], 2'b00}.
- mem_we = d_wstrb when it is a data write, else 4'b0000.
- mem_wdata = d_wdata.
REQ-026 SHALL drive mem_en=0 and mem_we=0 with no grant.
REQ-027 SHALL track the outstanding read in an FSM with states IDLE, RD_IF and RD_D:
- a fetch grant moves to RD_IF.
- a data read grant moves to RD_D.
- a write grant, or no grant, moves to IDLE.
REQ-028 SHALL assert if_rvalid=1 in RD_IF and d_rvalid=1 in RD_D, each exactly one cycle after its grant (read latency 1).
REQ-029 SHALL drive if_rdata/d_rdata = mem_rdata while the matching rvalid=1, else 32'h0.
REQ-030 SHALL return no rvalid for writes; a write is complete at the cycle d_gnt=1.
REQ-031 SHALL allow back-to-back grants every cycle, including a new grant in the same cycle as a previous read's rvalid (full throughput).
REQ-032 SHALL ignore if_addr/d_addr bits [1:0] for addressing; the requester handles byte selection.
REQ-033 SHALL keep a requester's request held until its gnt; the arbiter SHALL NOT store unaccepted requests.

Reset
REQ-034 SHALL, while rst_n=0, force these values:
- FSM to IDLE.
- starve_cnt=0.
- if_rvalid=0, d_rvalid=0.
- all rdata=0.
- if_gnt=0, d_gnt=0.
- mem_en=0, mem_we=0.
REQ-035 SHALL discard a read outstanding when reset asserts; no rvalid SHALL follow reset release.

Structure
REQ-036 SHALL take the FSM state encoding (IDLE/RD_IF/RD_D) and the STARVE_MAX default from the shared pipeline package.
REQ-037 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-038 SHALL cover this scenario: if_req=1 alone, if_addr=0x0000_1006 -> same cycle if_gnt=1, mem_addr=0x0000_1004; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-039 SHALL cover this scenario: d_req=1, d_we=1, d_wstrb=4'b0011, d_wdata=0xDEAD_BEEF -> d_gnt=1, mem_we=4'b0011, mem_wdata=0xDEAD_BEEF; next cycle d_rvalid=0.
REQ-040 SHALL cover this scenario: if_req and d_req (read) held high continuously, STARVE_MAX=4 -> d_gnt for 4 cycles, then if_gnt on the 5th, then starve_cnt=0 and data wins again.
REQ-041 SHALL cover this scenario: fetch grant cycle N, data read grant cycle N+1 -> if_rvalid=1 at N+1, d_rvalid=1 at N+2, each carrying its own mem_rdata.
REQ-042 SHALL cover this scenario: data read granted, rst_n pulled low before the next edge, then released -> no d_rvalid, all outputs 0, FSM IDLE.
REQ-043 SHALL cover this scenario: no requests for 10 cycles -> mem_en=0 and both rvalid=0 throughout.
